// File: rtl/priority_encoder_rr_pkg.sv
// Shared definitions for the registered priority encoder.
// Holds the mode encodings and the modulo-N index helper. Both the top and the
// bench rely on these encodings, so they are kept in one place.
package priority_encoder_rr_pkg;

  // Encodings for the mode input.
  localparam logic PRI_MODE_FIXED = 1'b0;
  localparam logic PRI_MODE_RR    = 1'b1;

  // (a + b) mod n for operands already in [0, n). The index space wraps at N
  // rather than at 2^IW, which matters for non-power-of-two widths.
  function automatic int mod_add(input int a, input int b, input int n);
    int sum;
    sum = a + b;
    if (sum >= n) begin
      sum = sum - n;
    end
    return sum;
  endfunction

endpackage

// File: rtl/priority_encoder_rr_pri_enc_core.sv
// Purpose: combinational highest-set-bit finder over an N-bit vector.
// Latency: zero (pure combinational).
// Backpressure: none; the caller decides when to capture the result.
//
// Ports:
//   vec    in  N   vector to search
//   found  out 1   at least one bit of vec is set
//   idx    out IW  position of the highest set bit (0 when nothing is set)
module pri_enc_core #(
  parameter int N  = 8,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  vec,
  output logic          found,
  output logic [IW-1:0] idx
);

  always_comb begin
    found = |vec;
    idx   = '0;
    // Ascending scan: the last set bit seen is the highest one.
    for (int i = 0; i < N; i++) begin
      if (vec[i]) begin
        idx = IW'(i);
      end
    end
  end

endmodule

// File: rtl/priority_encoder_rr.sv
// Purpose: registered N-to-log2(N) priority encoder, fixed or round-robin priority.
// Latency: one cycle from req to out_valid/out_idx/out_onehot.
// Backpressure: while out_valid=1 and out_ready=0 the grant and pointer hold and req is ignored.
//
// Ports:
//   clk         in   1   rising-edge clock
//   rst_n       in   1   asynchronous active-low reset
//   req         in   N   request vector
//   mode        in   1   PRI_MODE_FIXED (bit N-1 highest) or PRI_MODE_RR
//   out_ready   in   1   consumer accepts the current grant
//   out_valid   out  1   grant outputs are valid
//   out_idx     out  IW  encoded index of the granted request
//   out_onehot  out  N   one-hot form of out_idx, zero when out_valid=0
module priority_encoder_rr
  import priority_encoder_rr_pkg::*;
#(
  parameter int N  = 8,
  parameter int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          mode,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [IW-1:0] out_idx,
  output logic [N-1:0]  out_onehot
);

  logic [IW-1:0] ptr;
  logic [IW-1:0] base;
  logic [N-1:0]  rot;
  logic          found;
  logic [IW-1:0] rot_idx;
  logic [IW-1:0] winner;
  logic [N-1:0]  winner_onehot;
  logic          load;

  // Round-robin search order is ptr-1, ptr-2, ..., 0, N-1, ..., ptr. Placing
  // req[(base + j) mod N] at rot[j] turns that order into a plain
  // highest-bit-first search, with req[ptr] landing at rot[0] (searched last).
  // Fixed mode uses base=0, so rot equals req and bit N-1 wins.
  assign base = (mode == PRI_MODE_RR) ? ptr : '0;

  always_comb begin
    rot = '0;
    for (int j = 0; j < N; j++) begin
      rot[j] = req[IW'(mod_add(int'(base), j, N))];
    end
  end

  pri_enc_core #(
    .N  (N),
    .IW (IW)
  ) u_core (
    .vec   (rot),
    .found (found),
    .idx   (rot_idx)
  );

  // Undo the rotation, modulo N.
  assign winner = IW'(mod_add(int'(base), int'(rot_idx), N));

  always_comb begin
    winner_onehot = '0;
    for (int i = 0; i < N; i++) begin
      winner_onehot[i] = (winner == IW'(i));
    end
  end

  // A new grant is captured whenever the current one is absent or retiring.
  assign load = !out_valid || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_idx    <= '0;
      out_onehot <= '0;
      ptr        <= '0;
    end else if (load) begin
      if (found) begin
        out_valid  <= 1'b1;
        out_idx    <= winner;
        out_onehot <= winner_onehot;
        // Fixed-mode grants also move the pointer so a later switch to
        // round-robin continues from the last serviced index.
        ptr        <= winner;
      end else begin
        out_valid  <= 1'b0;
        out_idx    <= '0;
        out_onehot <= '0;
      end
    end
  end

endmodule

// File: tb/tb_priority_encoder_rr.sv
module tb_priority_encoder_rr;

  logic       clk;
  logic       rst_n;

  logic [7:0] req8;
  logic       mode8;
  logic       rdy8;
  logic       v8;
  logic [2:0] idx8;
  logic [7:0] oh8;

  logic [4:0] req5;
  logic       mode5;
  logic       rdy5;
  logic       v5;
  logic [2:0] idx5;
  logic [4:0] oh5;

  int checks;
  int failures;

  // Reference state per instance
  bit m8_v;  int m8_idx;  int m8_ptr;
  bit m5_v;  int m5_idx;  int m5_ptr;

  typedef struct {
    bit         rst;
    logic [7:0] req;
    logic       mode;
    logic       rdy;
    bit         exp_v;
    int         exp_idx;
  } row_t;

  row_t rows[$];

  priority_encoder_rr #(.N(8)) dut8 (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req8),
    .mode       (mode8),
    .out_ready  (rdy8),
    .out_valid  (v8),
    .out_idx    (idx8),
    .out_onehot (oh8)
  );

  priority_encoder_rr #(.N(5)) dut5 (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req5),
    .mode       (mode5),
    .out_ready  (rdy5),
    .out_valid  (v5),
    .out_idx    (idx5),
    .out_onehot (oh5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Winner straight from the rules: fixed -> highest set bit; round-robin ->
  // walk downward from ptr-1, wrapping modulo n, with ptr itself last.
  function automatic int ref_winner(input int n, input logic [31:0] r, input int p, input logic m);
    if (m == 1'b0) begin
      for (int i = n - 1; i >= 0; i--) if (r[i]) return i;
    end else begin
      for (int k = 1; k <= n; k++) begin
        int i;
        i = (p - k + n) % n;
        if (r[i]) return i;
      end
    end
    return -1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_models();
    chk("n8_valid",  32'(v8),   32'(m8_v));
    chk("n8_idx",    32'(idx8), m8_v ? 32'(m8_idx) : 32'd0);
    chk("n8_onehot", 32'(oh8),  m8_v ? (32'd1 << m8_idx) : 32'd0);
    chk("n5_valid",  32'(v5),   32'(m5_v));
    chk("n5_idx",    32'(idx5), m5_v ? 32'(m5_idx) : 32'd0);
    chk("n5_onehot", 32'(oh5),  m5_v ? (32'd1 << m5_idx) : 32'd0);
  endtask

  task automatic model_reset();
    m8_v = 0; m8_idx = 0; m8_ptr = 0;
    m5_v = 0; m5_idx = 0; m5_ptr = 0;
  endtask

  // One clock edge: advance the references from the inputs the DUT samples,
  // then compare just after the edge.
  task automatic step();
    int w;
    @(posedge clk);
    if (!m8_v || rdy8) begin
      w = ref_winner(8, 32'(req8), m8_ptr, mode8);
      if (w >= 0) begin m8_v = 1; m8_idx = w; m8_ptr = w; end
      else begin m8_v = 0; m8_idx = 0; end
    end
    if (!m5_v || rdy5) begin
      w = ref_winner(5, 32'(req5), m5_ptr, mode5);
      if (w >= 0) begin m5_v = 1; m5_idx = w; m5_ptr = w; end
      else begin m5_v = 0; m5_idx = 0; end
    end
    #1;
    chk_models();
  endtask

  // Reset held across a clock edge, released on a falling edge.
  task automatic full_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    model_reset();
    chk_models();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Called just after a rising edge: pulse reset wholly between two edges.
  task automatic mid_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_n8_valid", 32'(v8), 32'd0);
    chk("midrst_n5_valid", 32'(v5), 32'd0);
    chk("midrst_n8_onehot", 32'(oh8), 32'd0);
    model_reset();
    #2 rst_n = 1'b1;
  endtask

  function automatic row_t mk(input bit rst, input logic [7:0] r, input logic m,
                              input logic rd, input bit ev, input int ei);
    row_t x;
    x.rst = rst; x.req = r; x.mode = m; x.rdy = rd; x.exp_v = ev; x.exp_idx = ei;
    return x;
  endfunction

  initial begin
    checks   = 0;
    failures = 0;
    rst_n = 1'b0;
    req8 = '0; mode8 = 1'b0; rdy8 = 1'b1;
    req5 = '0; mode5 = 1'b0; rdy5 = 1'b1;
    model_reset();

    // Reset state
    #3;
    chk_models();
    @(negedge clk);
    rst_n = 1'b1;

    // Fixed mode basics
    rows.push_back(mk(0, 8'h01, 0, 1, 1, 0));
    rows.push_back(mk(0, 8'h96, 0, 1, 1, 7));
    rows.push_back(mk(0, 8'h00, 0, 1, 0, 0));
    // Round-robin rotation over all-ones, from reset
    rows.push_back(mk(1, 8'hFF, 1, 1, 1, 7));
    for (int k = 6; k >= 0; k--) rows.push_back(mk(0, 8'hFF, 1, 1, 1, k));
    rows.push_back(mk(0, 8'hFF, 1, 1, 1, 7));
    // Round-robin over two requests, then switch to fixed
    rows.push_back(mk(1, 8'h81, 1, 1, 1, 7));
    rows.push_back(mk(0, 8'h81, 1, 1, 1, 0));
    rows.push_back(mk(0, 8'h81, 1, 1, 1, 7));
    rows.push_back(mk(0, 8'h81, 1, 1, 1, 0));
    rows.push_back(mk(0, 8'h81, 0, 1, 1, 7));
    rows.push_back(mk(0, 8'h81, 0, 1, 1, 7));
    // Backpressure: grant 3 held while req changes
    rows.push_back(mk(1, 8'h08, 0, 1, 1, 3));
    for (int k = 0; k < 4; k++) rows.push_back(mk(0, 8'h80, 0, 0, 1, 3));
    rows.push_back(mk(0, 8'h80, 0, 1, 1, 7));

    foreach (rows[i]) begin
      if (rows[i].rst) full_reset();
      req8 = rows[i].req; mode8 = rows[i].mode; rdy8 = rows[i].rdy;
      step();
      chk($sformatf("row%0d_valid", i), 32'(v8), 32'(rows[i].exp_v));
      chk($sformatf("row%0d_idx", i), 32'(idx8), 32'(rows[i].exp_idx));
      chk($sformatf("row%0d_onehot", i), 32'(oh8),
          rows[i].exp_v ? (32'd1 << rows[i].exp_idx) : 32'd0);
    end

    // Reset mid-operation with ptr=5, then first grant restarts at 7
    full_reset();
    req8 = 8'hFF; mode8 = 1'b1; rdy8 = 1'b1;
    step(); step(); step();
    chk("ptr5_idx", 32'(idx8), 32'd5);
    mid_reset();
    step();
    chk("post_reset_idx", 32'(idx8), 32'd7);
    chk("post_reset_valid", 32'(v8), 32'd1);

    // N=5: modulo-5 wrap and fixed mode
    req8 = '0;
    full_reset();
    req5 = 5'b10001; mode5 = 1'b1; rdy5 = 1'b1;
    step(); chk("n5_rr_a", 32'(idx5), 32'd4);
    step(); chk("n5_rr_b", 32'(idx5), 32'd0);
    step(); chk("n5_rr_c", 32'(idx5), 32'd4);
    req5 = 5'b00110; mode5 = 1'b0;
    step(); chk("n5_fixed", 32'(idx5), 32'd2);
    chk("n5_fixed_oh", 32'(oh5), 32'h04);

    // Randomised traffic against the references
    for (int c = 0; c < 3000; c++) begin
      req8  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      req5  = ($urandom_range(0, 7) == 0) ? 5'h00 : 5'($urandom);
      rdy8  = ($urandom_range(0, 3) != 0);
      rdy5  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) mode8 = ~mode8;
      if ($urandom_range(0, 15) == 0) mode5 = ~mode5;
      step();
      if ($urandom_range(0, 299) == 0) mid_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
